// File: rtl/operand_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_ctrl_pkg
// Description : Shared constants for operand_ctrl and the memory stage it
//               drives: memory-stage command codes, ALU op codes, FSM state
//               encoding and the datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_ctrl_pkg;

  localparam int unsigned DATA_W = 4;

  // Commands sent to the memory stage on tx (the memory stage decodes the
  // same values, so keep them stable).
  typedef enum logic [3:0] {
    TX_CLEAR = 4'd0,
    TX_LOAD  = 4'd1,
    TX_HOLD  = 4'd2
  } tx_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LD1  = 3'd2,
    ST_LD2  = 3'd3,
    ST_CAP  = 3'd4,
    ST_EXEC = 3'd5,
    ST_DONE = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/operand_ctrl_ula.sv
`default_nettype none
// ============================================================================
// Module      : ula
// Description : Combinational 4-bit ALU used by operand_ctrl.
// Ports       : a, b    - operands
//               op      - 00 add, 01 sub, 10 and, 11 or
//               result  - operation result (mod 16)
//               carry   - add carry-out / sub borrow (a < b); 0 for and/or
// Revision    : 1.0 - initial release
// ============================================================================
module ula
  import operand_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // Both widened by one bit: the top bit of the sum is the carry-out, and
  // the top bit of the wrapped difference is set exactly when a < b.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = w_sum[DATA_W-1:0];
        carry  = w_sum[DATA_W];
      end
      OP_SUB: begin
        result = w_diff[DATA_W-1:0];
        carry  = w_diff[DATA_W];
      end
      OP_AND:  result = a & b;
      default: result = a | b;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/operand_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : operand_ctrl
// Description : Moore FSM that clears and loads two operands from a memory
//               stage, runs one ALU operation and holds the result until the
//               consumer acknowledges it.
// Ports       : clock, reset_n (sync, active-low)
//               start   - begin a sequence (only honoured in IDLE)
//               op      - operation, latched when the sequence starts
//               ack     - result acknowledge (only honoured in DONE)
//               entrada - operand word from the memory stage
//               tx      - command to the memory stage (CLEAR/LOAD/HOLD)
//               reg_a, reg_b, result, carry - captured operands and result
//               busy    - sequence in flight; done - result valid
// Revision    : 1.0 - initial release
// ============================================================================
module operand_ctrl
  import operand_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              ack,
  input  logic [DATA_W-1:0] entrada,
  output logic [3:0]        tx,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] reg_a_q, reg_a_d;
  logic [DATA_W-1:0] reg_b_q, reg_b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_q, carry_d;

  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CLR;
      ST_CLR:  state_d = ST_LD1;
      ST_LD1:  state_d = ST_LD2;
      ST_LD2:  state_d = ST_CAP;
      ST_CAP:  state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      // start arriving together with ack is deliberately ignored here.
      ST_DONE: if (ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    tx   = TX_HOLD;
    busy = 1'b1;
    done = 1'b0;
    case (state_q)
      ST_IDLE: busy = 1'b0;
      ST_CLR:  tx   = TX_CLEAR;
      ST_LD1:  tx   = TX_LOAD;
      ST_LD2:  tx   = TX_LOAD;
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  // The memory stage answers a LOAD one edge later, so the first operand is
  // on entrada while in CAP's predecessor (LD2) is being left, and the second
  // one while CAP is being left.
  always_comb begin
    op_d     = op_q;
    reg_a_d  = reg_a_q;
    reg_b_d  = reg_b_q;
    result_d = result_q;
    carry_d  = carry_q;
    case (state_q)
      ST_IDLE: if (start) op_d = op;
      ST_LD2:  reg_a_d = entrada;
      ST_CAP:  reg_b_d = entrada;
      ST_EXEC: begin
        result_d = w_alu_result;
        carry_d  = w_alu_carry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      op_q     <= OP_ADD;
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      op_q     <= op_d;
      reg_a_q  <= reg_a_d;
      reg_b_q  <= reg_b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  ula u_ula (
    .a      (reg_a_q),
    .b      (reg_b_q),
    .op     (op_q),
    .result (w_alu_result),
    .carry  (w_alu_carry)
  );

  assign reg_a  = reg_a_q;
  assign reg_b  = reg_b_q;
  assign result = result_q;
  assign carry  = carry_q;

endmodule
`default_nettype wire

// File: doc/operand_ctrl.md
OPERAND_CTRL -- requirements
Module: operand_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 Ports SHALL be:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  request one load/execute sequence
- op  in  2  operation: 00 add, 01 sub, 10 and, 11 or
- ack  in  1  consumer acknowledges result
- entrada  in  4  operand word from the memory stage
- tx  out  4  command to the memory stage: CLEAR=0, LOAD=1, HOLD=2
- reg_a  out  4  first captured operand
- reg_b  out  4  second captured operand
- result  out  4  operation result
- carry  out  1  add carry-out / sub borrow; 0 for and/or
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  result valid; held until acknowledged

Function
REQ-003 SHALL be a Moore FSM with states IDLE, CLR, LD1, LD2, CAP, EXEC, DONE; tx decoded from state only.
REQ-004 tx per state SHALL be: IDLE HOLD, CLR CLEAR, LD1 LOAD, LD2 LOAD, CAP HOLD, EXEC HOLD, DONE HOLD.
REQ-005 IDLE->CLR SHALL occur on an edge with start=1; otherwise IDLE holds.
REQ-006 CLR->LD1->LD2->CAP->EXEC SHALL advance unconditionally, one state per edge.
REQ-007 The edge leaving LD2 SHALL capture entrada into reg_a; the edge leaving CAP SHALL capture entrada into reg_b (memory stage updates entrada one edge after sampling LOAD).
REQ-008 op SHALL be latched on the IDLE->CLR edge; later op changes SHALL not affect the sequence.
REQ-009 The edge leaving EXEC SHALL register result and carry from reg_a, reg_b and latched op, and enter DONE.
REQ-010 Arithmetic: add {carry,result}=reg_a+reg_b (5-bit); sub result=reg_a-reg_b mod 16, carry=1 iff reg_a<reg_b; and/or bitwise, carry=0.
REQ-011 done SHALL be 1 exactly while in DONE; DONE->IDLE on an edge with ack=1, else hold.
REQ-012 start SHALL be ignored outside IDLE, including in DONE simultaneous with ack; a new sequence requires start in IDLE.
REQ-013 ack SHALL be ignored outside DONE.
REQ-014 Latency: start sampled at edge N -> done=1 after edge N+5.
REQ-015 reg_a, reg_b, result, carry SHALL hold their values until overwritten by a new sequence.

Reset
REQ-016 reset_n=0 at an edge SHALL force state IDLE, tx=HOLD, reg_a=reg_b=result=0, carry=0, busy=0, done=0, latched op=00.
REQ-017 Reset SHALL take priority over start, ack and any in-flight sequence; an aborted sequence SHALL produce no done.

Structure
REQ-018 A shared package SHALL hold tx codes (CLEAR, LOAD, HOLD), op codes and the FSM state encoding; the memory stage uses the same tx constants.
REQ-019 Arithmetic SHALL be one combinational sub-module named ula (inputs a, b, op; outputs result, carry); the FSM, registers and handshake stay in operand_ctrl.

Verification
REQ-020 Bench SHALL model the memory stage (n1 on first LOAD edge, n2 on second) and cover:
- n1=5, n2=3, op=00, start pulse -> tx sequence CLEAR,LOAD,LOAD,HOLD; reg_a=5, reg_b=3; done after 5 edges, result=8, carry=0.
- n1=5, n2=3, op=01 -> result=2, carry=0; op=10 -> result=1; op=11 -> result=7.
- n1=15, n2=1, op=00 -> result=0, carry=1; n1=3, n2=5, op=01 -> result=14, carry=1.
- ack withheld 4 cycles -> done and result stable throughout; ack=1 -> IDLE next edge, done=0; start during busy ignored.
- reset_n=0 while in LD2 -> next edge IDLE, tx=HOLD, all outputs 0, no done pulse.
- start=1 and ack=1 together in DONE -> IDLE, no new sequence until start reasserted in IDLE.
